// File: rtl/cs_pipe_sequencer_if.sv
// ---------------------------------------------------------------------------
// cs_pipe_sequencer_if
// Bundles every non-clock/reset signal of the center/scale sequencer.
//   s_*    : input sample stream (valid/ready)
//   cfg_*  : configuration load request and busy indication
//   dp_*   : issue/return port towards the fixed-latency datapath
//   m_*    : output FIFO stream (valid/ready)
//   err_sticky : [0] FIFO overflow, [1] datapath return with nothing in flight
// Modport slave is the sequencer's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface cs_pipe_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [20:0] s_data;
    logic        cfg_we;
    logic [31:0] cfg_mean;
    logic [31:0] cfg_std;
    logic        cfg_busy;
    logic        dp_srdyi;
    logic [20:0] dp_x_adc;
    logic [31:0] dp_mean;
    logic [31:0] dp_std;
    logic [31:0] dp_result;
    logic        dp_srdyo;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  err_sticky;

    modport slave (
        input  s_valid, s_data, cfg_we, cfg_mean, cfg_std, dp_result, dp_srdyo, m_ready,
        output s_ready, cfg_busy, dp_srdyi, dp_x_adc, dp_mean, dp_std, m_valid, m_data,
               err_sticky
    );

    modport master (
        output s_valid, s_data, cfg_we, cfg_mean, cfg_std, dp_result, dp_srdyo, m_ready,
        input  s_ready, cfg_busy, dp_srdyi, dp_x_adc, dp_mean, dp_std, m_valid, m_data,
               err_sticky
    );
endinterface

// File: rtl/cs_pipe_sequencer.sv
// ---------------------------------------------------------------------------
// cs_pipe_sequencer
// Feeds the center/scale datapath (fixed LATENCY, no stall) from a valid/ready
// sample port, credit-limits issue so every result always has a slot in the
// output FIFO, and swaps mean/std only once the datapath has drained.
// Ports:
//   clk          posedge clock
//   GlobalReset  synchronous active-high reset, discards all in-flight data
//   bus          cs_pipe_sequencer_if.slave (sample in, config, datapath, FIFO out)
// Parameters:
//   LATENCY      cycles from dp_srdyi to dp_srdyo
//   OUT_DEPTH    output FIFO entries (power of 2, >= 2); also total credit
// ---------------------------------------------------------------------------
module cs_pipe_sequencer #(
    parameter int LATENCY   = 18,
    parameter int OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               GlobalReset,
    cs_pipe_sequencer_if.slave bus
);

    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    // The pipe can never hold more than LATENCY issues, nor more than the credit.
    localparam int INF_MAX = (LATENCY < OUT_DEPTH) ? LATENCY : OUT_DEPTH;
    localparam int INF_W   = $clog2(INF_MAX + 1);

    localparam logic [CNT_W:0]   TOTAL_LIMIT = (CNT_W + 1)'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] COUNT_FULL  = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [INF_W-1:0] INF_ONE     = INF_W'(1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_shadow_mean;
    logic [31:0]      r_shadow_std;
    logic [31:0]      r_dp_mean;
    logic [31:0]      r_dp_std;
    logic             r_dp_srdyi;
    logic [20:0]      r_dp_x_adc;
    logic [INF_W-1:0] r_inflight;
    logic [31:0]      r_mem [OUT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_err;

    logic [CNT_W:0]   w_total;
    logic             w_credit_ok;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_stray;
    logic             w_ret;
    logic             w_m_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_overflow;
    logic             w_drained;
    logic             w_cfg_take;

    // Credit, handshake and FIFO control decode.
    always_comb begin
        // r_inflight already contains an issue registered this cycle, so one accept
        // per cycle can never overcommit the FIFO.
        w_total     = {{(CNT_W + 1 - INF_W){1'b0}}, r_inflight} + {1'b0, r_count};
        w_credit_ok = (w_total < TOTAL_LIMIT);
        w_s_ready   = (r_state == ST_RUN) & w_credit_ok;
        w_accept    = bus.s_valid & w_s_ready;
        w_stray     = bus.dp_srdyo & (r_inflight == {INF_W{1'b0}});
        w_ret       = bus.dp_srdyo & ~w_stray;
        w_m_valid   = (r_count != {CNT_W{1'b0}});
        w_full      = (r_count == COUNT_FULL);
        w_pop       = bus.m_ready & w_m_valid;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
        w_push_ok   = bus.dp_srdyo & (~w_full | w_pop);
        w_overflow  = bus.dp_srdyo & w_full & ~w_pop;
        w_drained   = (r_inflight == {INF_W{1'b0}}) & ~r_dp_srdyi;
        w_cfg_take  = (r_state == ST_RUN) & bus.cfg_we;
    end

    // Next-state logic for the RUN / DRAIN / LOAD configuration FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.cfg_we) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow copy of a requested configuration; later requests while busy are ignored.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_shadow_mean <= 32'd0;
            r_shadow_std  <= 32'd0;
        end else if (w_cfg_take) begin
            r_shadow_mean <= bus.cfg_mean;
            r_shadow_std  <= bus.cfg_std;
        end else begin
            r_shadow_mean <= r_shadow_mean;
            r_shadow_std  <= r_shadow_std;
        end
    end

    // Active configuration: copied on the DRAIN->LOAD edge, so the new values are
    // already stable for the whole LOAD cycle before issue resumes in RUN.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_dp_mean <= 32'd0;
            r_dp_std  <= 32'd0;
        end else if ((r_state == ST_DRAIN) && w_drained) begin
            r_dp_mean <= r_shadow_mean;
            r_dp_std  <= r_shadow_std;
        end else begin
            r_dp_mean <= r_dp_mean;
            r_dp_std  <= r_dp_std;
        end
    end

    // Issue strobe and sample register towards the datapath.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_dp_srdyi <= 1'b0;
            r_dp_x_adc <= 21'd0;
        end else if (w_accept) begin
            r_dp_srdyi <= 1'b1;
            r_dp_x_adc <= bus.s_data;
        end else begin
            r_dp_srdyi <= 1'b0;
            r_dp_x_adc <= r_dp_x_adc;
        end
    end

    // In-flight counter; a stray return does not decrement below zero.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_inflight <= {INF_W{1'b0}};
        end else begin
            case ({w_accept, w_ret})
                2'b10:   r_inflight <= r_inflight + INF_ONE;
                2'b01:   r_inflight <= r_inflight - INF_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output FIFO storage; cleared on reset so m_data reads zero afterwards.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.dp_result;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_err <= 2'b00;
        end else begin
            r_err <= r_err | {w_stray, w_overflow};
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.cfg_busy   = (r_state != ST_RUN);
    assign bus.dp_srdyi   = r_dp_srdyi;
    assign bus.dp_x_adc   = r_dp_x_adc;
    assign bus.dp_mean    = r_dp_mean;
    assign bus.dp_std     = r_dp_std;
    assign bus.m_valid    = w_m_valid;
    assign bus.m_data     = r_mem[r_rd_ptr];
    assign bus.err_sticky = r_err;

endmodule

// File: tb/tb_cs_pipe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cs_pipe_sequencer
// Directed bench for cs_pipe_sequencer. A behavioural fixed-latency datapath
// stands in for the real centre/scale unit; its result function only has to
// depend on x, mean and std so that configuration mixing is visible.
// ---------------------------------------------------------------------------
module tb_cs_pipe_sequencer;

    localparam int LAT   = 18;
    localparam int DEPTH = 4;

    localparam logic [31:0] C0M = 32'h1234_0000;
    localparam logic [31:0] C0S = 32'h0000_0100;
    localparam logic [31:0] C1M = 32'h3F80_0000;
    localparam logic [31:0] C1S = 32'h4000_0000;
    localparam logic [31:0] C2M = 32'h0000_0040;
    localparam logic [31:0] C2S = 32'h0000_0003;
    localparam logic [31:0] C3M = 32'h7777_0000;
    localparam logic [31:0] C3S = 32'h0000_0777;

    logic        clk;
    logic        rst;
    logic        inj;
    logic [31:0] inj_data;
    logic [LAT-1:0] pv;
    logic [31:0] pd [LAT];
    logic [31:0] exp_q [$];
    int          n_assert;
    int          n_fail;
    int          srdyo_cnt;
    logic        last_hs;

    cs_pipe_sequencer_if bus ();

    cs_pipe_sequencer #(.LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .GlobalReset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [20:0] x, input logic [31:0] m,
                                      input logic [31:0] s);
        return {11'd0, x} + m + {s[30:0], 1'b0};
    endfunction

    function automatic logic [20:0] xs(input int i);
        return 21'(32'h0001_0000 + 32'(i) * 32'd291);
    endfunction

    function automatic logic [20:0] zs(input int i);
        return 21'(32'h001F_0000 + 32'(i) * 32'd7);
    endfunction

    // Datapath model: result captured with the config present at issue time.
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[LAT-2:0], bus.dp_srdyi};
        end
        pd[0] <= f(bus.dp_x_adc, bus.dp_mean, bus.dp_std);
        for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end

    assign bus.dp_srdyo  = pv[LAT-1] | inj;
    assign bus.dp_result = pv[LAT-1] ? pd[LAT-1] : inj_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: records handshake/return, checks any pop against the queue.
    task automatic cycle();
        logic pop;
        logic [31:0] e;
        pop     = bus.m_valid & bus.m_ready;
        last_hs = bus.s_valid & bus.s_ready;
        if (bus.dp_srdyo) srdyo_cnt++;
        if (pop) begin
            chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("m_data_order", 64'(bus.m_data), 64'(e));
            end
        end
        tick();
    endtask

    initial begin
        int n;
        int acc;
        n_assert = 0; n_fail = 0; srdyo_cnt = 0; last_hs = 1'b0;
        rst = 1'b1; inj = 1'b0; inj_data = 32'd0;
        bus.s_valid = 1'b0; bus.s_data = 21'd0; bus.cfg_we = 1'b0;
        bus.cfg_mean = 32'd0; bus.cfg_std = 32'd0; bus.m_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data", 64'(bus.m_data), 64'd0);
        chk("rst_dp_srdyi", 64'(bus.dp_srdyi), 64'd0);
        chk("rst_dp_x_adc", 64'(bus.dp_x_adc), 64'd0);
        chk("rst_dp_mean", 64'(bus.dp_mean), 64'd0);
        chk("rst_dp_std", 64'(bus.dp_std), 64'd0);
        chk("rst_cfg_busy", 64'(bus.cfg_busy), 64'd0);
        chk("rst_err", 64'(bus.err_sticky), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Initial config load with an empty pipe: RUN -> DRAIN -> LOAD -> RUN
        bus.cfg_we = 1'b1; bus.cfg_mean = C0M; bus.cfg_std = C0S;
        cycle();
        bus.cfg_we = 1'b0;
        chk("cfg0_busy", 64'(bus.cfg_busy), 64'd1);
        chk("cfg0_s_ready", 64'(bus.s_ready), 64'd0);
        chk("cfg0_mean_old", 64'(bus.dp_mean), 64'd0);
        cycle();
        chk("cfg0_mean", 64'(bus.dp_mean), 64'(C0M));
        chk("cfg0_std", 64'(bus.dp_std), 64'(C0S));
        chk("cfg0_busy_load", 64'(bus.cfg_busy), 64'd1);
        cycle();
        chk("cfg0_busy_run", 64'(bus.cfg_busy), 64'd0);
        chk("cfg0_s_ready_run", 64'(bus.s_ready), 64'd1);

        // 1: single sample, latency and result
        bus.m_ready = 1'b1;
        exp_q.push_back(f(21'h0ABCDE, C0M, C0S));
        bus.s_valid = 1'b1; bus.s_data = 21'h0ABCDE;
        cycle();
        bus.s_valid = 1'b0;
        chk("t1_dp_srdyi", 64'(bus.dp_srdyi), 64'd1);
        chk("t1_dp_x_adc", 64'(bus.dp_x_adc), 64'h0ABCDE);
        chk("t1_inflight1", 64'(dut.r_inflight), 64'd1);
        cycle();
        n = 2;
        chk("t1_srdyi_pulse", 64'(bus.dp_srdyi), 64'd0);
        while (!bus.m_valid && n < 60) begin cycle(); n++; end
        chk("t1_latency", 64'(n), 64'(LAT + 2));
        cycle();
        chk("t1_m_valid_after", 64'(bus.m_valid), 64'd0);
        chk("t1_inflight0", 64'(dut.r_inflight), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: 32-sample stream, consumer stalled then released
        bus.m_ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_q.push_back(f(xs(i), C0M, C0S));
        acc = 0;
        bus.s_valid = 1'b1; bus.s_data = xs(0);
        for (int c = 0; c < 600 && exp_q.size() > 0; c++) begin
            if (c == 40) begin
                chk("t2_accepts_at_stall", 64'(acc), 64'(DEPTH));
                chk("t2_s_ready_stall", 64'(bus.s_ready), 64'd0);
                chk("t2_err_stall", 64'(bus.err_sticky), 64'd0);
                chk("t2_fifo_full", 64'(dut.r_count), 64'(DEPTH));
                bus.m_ready = 1'b1;
            end
            cycle();
            if (last_hs) begin
                acc++;
                if (acc < 32) bus.s_data = xs(acc); else bus.s_valid = 1'b0;
            end
        end
        bus.s_valid = 1'b0;
        chk("t2_all_results", 64'(exp_q.size()), 64'd0);
        chk("t2_accepts", 64'(acc), 64'd32);
        chk("t2_err", 64'(bus.err_sticky), 64'd0);

        // 3: config change with 3 in flight; third handshake shares the cfg_we cycle
        exp_q.push_back(f(21'h000111, C0M, C0S));
        exp_q.push_back(f(21'h000222, C0M, C0S));
        exp_q.push_back(f(21'h000333, C0M, C0S));
        exp_q.push_back(f(21'h000444, C1M, C1S));
        srdyo_cnt = 0;
        bus.s_valid = 1'b1; bus.s_data = 21'h000111;
        cycle();
        bus.s_data = 21'h000222;
        cycle();
        bus.s_data = 21'h000333; bus.cfg_we = 1'b1; bus.cfg_mean = C1M; bus.cfg_std = C1S;
        cycle();
        chk("t3_third_hs", 64'(last_hs), 64'd1);
        bus.cfg_we = 1'b0; bus.s_data = 21'h000444;
        chk("t3_busy", 64'(bus.cfg_busy), 64'd1);
        chk("t3_x_old_cfg", 64'(bus.dp_x_adc), 64'h000333);
        chk("t3_mean_old", 64'(bus.dp_mean), 64'(C0M));
        n = 0;
        while (srdyo_cnt < 3 && n < 60) begin
            chk("t3_drain_s_ready", 64'(bus.s_ready), 64'd0);
            cycle(); n++;
        end
        chk("t3_returns", 64'(srdyo_cnt), 64'd3);
        chk("t3_mean_x1", 64'(bus.dp_mean), 64'(C0M));
        chk("t3_s_ready_x1", 64'(bus.s_ready), 64'd0);
        cycle();
        chk("t3_mean_x2", 64'(bus.dp_mean), 64'(C1M));
        chk("t3_std_x2", 64'(bus.dp_std), 64'(C1S));
        chk("t3_s_ready_x2", 64'(bus.s_ready), 64'd0);
        chk("t3_busy_x2", 64'(bus.cfg_busy), 64'd1);
        cycle();
        chk("t3_s_ready_x3", 64'(bus.s_ready), 64'd1);
        chk("t3_busy_x3", 64'(bus.cfg_busy), 64'd0);
        cycle();
        bus.s_valid = 1'b0;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) cycle();
        chk("t3_all_results", 64'(exp_q.size()), 64'd0);

        // 6: two cfg_we on consecutive cycles, second ignored
        bus.cfg_we = 1'b1; bus.cfg_mean = C2M; bus.cfg_std = C2S;
        cycle();
        bus.cfg_mean = C3M; bus.cfg_std = C3S;
        cycle();
        bus.cfg_we = 1'b0;
        chk("t6_mean", 64'(bus.dp_mean), 64'(C2M));
        chk("t6_std", 64'(bus.dp_std), 64'(C2S));
        cycle();
        cycle();
        chk("t6_busy", 64'(bus.cfg_busy), 64'd0);
        chk("t6_mean_hold", 64'(bus.dp_mean), 64'(C2M));
        exp_q.push_back(f(21'h012345, C2M, C2S));
        bus.s_valid = 1'b1; bus.s_data = 21'h012345;
        cycle();
        bus.s_valid = 1'b0;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) cycle();
        chk("t6_result", 64'(exp_q.size()), 64'd0);

        // 5a: stray return with nothing in flight
        bus.m_ready = 1'b0;
        inj = 1'b1; inj_data = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        cycle();
        inj = 1'b0;
        chk("t5_err_stray", 64'(bus.err_sticky), 64'h2);
        chk("t5_m_valid", 64'(bus.m_valid), 64'd1);
        chk("t5_m_data", 64'(bus.m_data), 64'hA5A5_0001);

        // 4: fill FIFO, then push and pop in the same cycle while full
        for (int i = 0; i < 3; i++) exp_q.push_back(f(zs(i), C2M, C2S));
        acc = 0;
        bus.s_valid = 1'b1; bus.s_data = zs(0);
        for (int c = 0; c < 80 && acc < 3; c++) begin
            cycle();
            if (last_hs) begin acc++; bus.s_data = zs(acc); end
        end
        bus.s_valid = 1'b0;
        for (int c = 0; c < 30; c++) cycle();
        chk("t4_accepts", 64'(acc), 64'd3);
        chk("t4_full", 64'(dut.r_count), 64'(DEPTH));
        chk("t4_s_ready_full", 64'(bus.s_ready), 64'd0);
        chk("t4_head_stable", 64'(bus.m_data), 64'hA5A5_0001);
        bus.m_ready = 1'b1; inj = 1'b1; inj_data = 32'hA5A5_0002;
        exp_q.push_back(32'hA5A5_0002);
        cycle();
        inj = 1'b0; bus.m_ready = 1'b0;
        chk("t4_count_kept", 64'(dut.r_count), 64'(DEPTH));
        chk("t4_no_overflow", 64'(bus.err_sticky), 64'h2);
        chk("t4_new_head", 64'(bus.m_data), 64'(f(zs(0), C2M, C2S)));

        // Overflow: push into a full FIFO without a pop is dropped
        inj = 1'b1; inj_data = 32'hDEAD_BEEF;
        cycle();
        inj = 1'b0;
        chk("t4_overflow_err", 64'(bus.err_sticky), 64'h3);
        chk("t4_overflow_count", 64'(dut.r_count), 64'(DEPTH));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        chk("t4_empty", 64'(bus.m_valid), 64'd0);

        // 5b: reset in the middle of activity
        bus.s_valid = 1'b1; bus.s_data = 21'h0ABCDE;
        cycle();
        bus.s_valid = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_mean = C1M; bus.cfg_std = C1S;
        cycle();
        bus.cfg_we = 1'b0;
        cycle(); cycle(); cycle();
        chk("t5_busy_before_rst", 64'(bus.cfg_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("t5_rst_m_data", 64'(bus.m_data), 64'd0);
        chk("t5_rst_dp_srdyi", 64'(bus.dp_srdyi), 64'd0);
        chk("t5_rst_dp_x_adc", 64'(bus.dp_x_adc), 64'd0);
        chk("t5_rst_dp_mean", 64'(bus.dp_mean), 64'd0);
        chk("t5_rst_dp_std", 64'(bus.dp_std), 64'd0);
        chk("t5_rst_busy", 64'(bus.cfg_busy), 64'd0);
        chk("t5_rst_err", 64'(bus.err_sticky), 64'd0);
        chk("t5_rst_inflight", 64'(dut.r_inflight), 64'd0);
        chk("t5_rst_s_ready", 64'(bus.s_ready), 64'd1);
        for (int c = 0; c < 30; c++) cycle();
        chk("t5_discarded", 64'(bus.m_valid), 64'd0);
        chk("t5_err_after", 64'(bus.err_sticky), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
